cfg_stream_loader: RTL and testbench
====================================

// Module: cfg_stream_loader
// PURPOSE
//  Writer side of the routing/logic configuration chain: takes a framed byte stream from the
//  host-side configuration port, checks it, then emits one 8-bit config word per cycle to the
//  connect_Config input of the chained config shift registers (connection/switch blocks).
//  Payload is buffered and released only after the checksum passes, so corrupt frames never reach the fabric.
// PARAMETERS
//  MAX_BYTES  16     payload capacity in bytes (buffer depth); legal LEN range is 1..MAX_BYTES
//  SYNC_BYTE  8'hA5  frame start marker
// PORTS
//  clk         in   1  single clock; all logic on posedge
//  reset       in   1  synchronous, active-high reset
//  in_data     in   8  stream byte
//  in_valid    in   1  in_data valid
//  in_ready    out  1  loader can accept; byte taken when in_valid && in_ready
//  cfg_data    out  8  config word to chain (connect_Config); 8'h00 when cfg_shift=0
//  cfg_shift   out  1  one-cycle strobe: cfg_data is a valid config word this cycle
//  cfg_done    out  1  one-cycle pulse: frame fully emitted
//  cfg_error   out  1  one-cycle pulse: frame rejected (bad LEN or checksum)
//  busy        out  1  high in any state other than IDLE
// BEHAVIOUR
//  Frame: SYNC_BYTE, LEN, LEN payload bytes P[0..LEN-1], CHK where CHK = XOR of P[0..LEN-1].
//  Reset (sync, active-high): state=IDLE; in_ready=1; cfg_data=0; cfg_shift=0; cfg_done=0;
//   cfg_error=0; busy=0; counters and checksum accumulator=0. Buffer contents need no reset.
//  States: IDLE -> LEN -> PAYLOAD -> CHECK -> EMIT -> DONE -> IDLE; ERR -> IDLE.
//  IDLE: in_ready=1. Accepted byte == SYNC_BYTE -> LEN; any other byte dropped silently, stay.
//  LEN: in_ready=1. Accepted byte 0 or > MAX_BYTES -> ERR; else latch LEN, clear XOR acc -> PAYLOAD.
//  PAYLOAD: in_ready=1. Each accepted byte written to buf[idx], acc ^= byte, idx++;
//   after byte LEN-1 accepted -> CHECK. in_valid low just stalls; no timeout.
//  CHECK: in_ready=1. Accepted byte == acc -> EMIT (idx=0); else -> ERR.
//  EMIT: in_ready=0. Each cycle cfg_shift=1, cfg_data=buf[idx], idx++; P[0] first, received order;
//   exactly LEN consecutive strobes, no gaps; after P[LEN-1] -> DONE.
//  DONE: cfg_done=1 for one cycle, in_ready=0 -> IDLE.
//  ERR: cfg_error=1 for one cycle, in_ready=0, nothing emitted -> IDLE.
//  Timing (CHK accepted in cycle t): strobes in t+1..t+LEN; cfg_done at t+LEN+1; in_ready=1 from t+LEN+2.
//   Rejection (CHK or bad LEN accepted in cycle t): cfg_error at t+1; in_ready=1 from t+2.
//  cfg_shift, cfg_done, cfg_error mutually exclusive; outputs registered (no comb path in->out).
//  SYNC_BYTE inside LEN/PAYLOAD/CHECK is ordinary data; no resync mid-frame.
//  LEN == MAX_BYTES is legal and fills the buffer exactly; idx never wraps.
//  Reset mid-EMIT: strobes stop the next cycle, no cfg_done; words already shifted stay in the
//   chain (no rollback); host reloads the full frame.
//  Counter widths: idx/LEN regs $clog2(MAX_BYTES+1) bits; LEN compare done on full 8-bit byte.
// TESTING
//  1. reset, then A5 03 11 22 44 77 -> strobes 11,22,44 in 3 consecutive cycles; cfg_done next cycle; no error.
//  2. A5 02 10 20 31 (bad CHK, expect 30) -> cfg_error 1 cycle after CHK; zero cfg_shift pulses; back to IDLE.
//  3. A5 00 and A5 11 (MAX_BYTES=16) -> cfg_error 1 cycle after LEN; then A5 01 5A 5A loads 5A normally.
//  4. 00 FF A5 01 A5 A5 with in_valid toggled every other cycle -> leading 00,FF dropped; single strobe A5; cfg_done.
//  5. A5 10 + 16 bytes 00..0F + CHK 00 -> 16 back-to-back strobes 00..0F; in_ready low throughout EMIT and DONE.
//  6. Frame A5 04 01 02 03 04 04, assert reset after 2nd strobe -> outputs at reset values next cycle,
//     no cfg_done; following clean frame loads correctly.

Source files
------------

// File: rtl/cfg_stream_loader.sv
// rtl/cfg_stream_loader.sv - framed config byte stream checker and config chain writer
//
// Receives frames of the form SYNC_BYTE, LEN, P[0..LEN-1], CHK (CHK = XOR of payload),
// buffers the payload, and only after the checksum matches shifts the payload into the
// config chain one word per cycle, P[0] first. Corrupt or malformed frames never reach
// the chain; they produce a single cfg_error pulse instead.
//
// Ports:
//   clk        - single clock, all logic on posedge
//   reset      - synchronous, active-high
//   in_data    - stream byte
//   in_valid   - in_data valid
//   in_ready   - byte accepted when in_valid && in_ready
//   cfg_data   - config word to chain, 8'h00 when cfg_shift is low
//   cfg_shift  - cfg_data is a valid config word this cycle
//   cfg_done   - one-cycle pulse, frame fully emitted
//   cfg_error  - one-cycle pulse, frame rejected (bad LEN or checksum)
//   busy       - high whenever not idle

module cfg_stream_loader #(
  parameter int          MAX_BYTES = 16,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] cfg_data,
  output logic       cfg_shift,
  output logic       cfg_done,
  output logic       cfg_error,
  output logic       busy
);

  // IW holds 0..MAX_BYTES; AW addresses the buffer itself.
  localparam int IW = $clog2(MAX_BYTES + 1);
  localparam int AW = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_PAYLOAD,
    S_CHECK,
    S_EMIT,
    S_DONE,
    S_ERR
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q;
  logic [IW-1:0]   len_q;
  logic [7:0]      acc_q;
  logic [7:0]      pbuf [MAX_BYTES];
  logic            accept;
  logic            last_idx;
  logic            len_bad;

  assign accept   = in_valid && in_ready;
  assign last_idx = (idx_q == len_q - IW'(1));
  // Range check on the full byte so values above MAX_BYTES cannot alias into range.
  assign len_bad  = (in_data == 8'd0) || (in_data > 8'(MAX_BYTES));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (accept && in_data == SYNC_BYTE) state_d = S_LEN;
      S_LEN:     if (accept) state_d = len_bad ? S_ERR : S_PAYLOAD;
      S_PAYLOAD: if (accept && last_idx) state_d = S_CHECK;
      S_CHECK:   if (accept) state_d = (in_data == acc_q) ? S_EMIT : S_ERR;
      S_EMIT:    if (last_idx) state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      S_ERR:     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Index, length and running checksum. idx counts payload bytes while receiving,
  // then is reused as the read pointer while emitting.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q <= '0;
      len_q <= '0;
      acc_q <= 8'd0;
    end else begin
      case (state_q)
        S_LEN: begin
          if (accept) begin
            len_q <= in_data[IW-1:0];
            acc_q <= 8'd0;
            idx_q <= '0;
          end
        end
        S_PAYLOAD: begin
          if (accept) begin
            acc_q <= acc_q ^ in_data;
            idx_q <= idx_q + IW'(1);
          end
        end
        S_CHECK: begin
          if (accept) idx_q <= '0;
        end
        S_EMIT: begin
          idx_q <= idx_q + IW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Payload buffer; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (state_q == S_PAYLOAD && accept) begin
      pbuf[idx_q[AW-1:0]] <= in_data;
    end
  end

  // All outputs decode only from flops, so there is no input-to-output path.
  always_comb begin
    in_ready  = (state_q == S_IDLE) || (state_q == S_LEN) ||
                (state_q == S_PAYLOAD) || (state_q == S_CHECK);
    cfg_shift = (state_q == S_EMIT);
    cfg_data  = cfg_shift ? pbuf[idx_q[AW-1:0]] : 8'h00;
    cfg_done  = (state_q == S_DONE);
    cfg_error = (state_q == S_ERR);
    busy      = (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_cfg_stream_loader.sv
// tb/tb_cfg_stream_loader.sv - directed self-checking bench for cfg_stream_loader

module tb_cfg_stream_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] cfg_data;
  logic       cfg_shift;
  logic       cfg_done;
  logic       cfg_error;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  int shift_cnt = 0;

  cfg_stream_loader #(.MAX_BYTES(16), .SYNC_BYTE(8'hA5)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cfg_data  (cfg_data),
    .cfg_shift (cfg_shift),
    .cfg_done  (cfg_done),
    .cfg_error (cfg_error),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cfg_shift === 1'b1) shift_cnt++;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cycle(input string tag, input logic sh, input logic [7:0] d,
                           input logic dn, input logic er, input logic rdy, input logic bsy);
    check({tag, ".shift"}, {7'd0, cfg_shift}, {7'd0, sh});
    check({tag, ".data"},  cfg_data, d);
    check({tag, ".done"},  {7'd0, cfg_done}, {7'd0, dn});
    check({tag, ".error"}, {7'd0, cfg_error}, {7'd0, er});
    check({tag, ".ready"}, {7'd0, in_ready}, {7'd0, rdy});
    check({tag, ".busy"},  {7'd0, busy}, {7'd0, bsy});
  endtask

  // Present one byte for exactly one clock edge, then drop valid.
  task automatic send(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Idle cycle with garbage on the data lines, then the byte.
  task automatic send_slow(input logic [7:0] b);
    in_data  = 8'($urandom);
    in_valid = 1'b0;
    @(negedge clk);
    send(b);
  endtask

  // Called right after the CHK byte was taken: expects len strobes, done, then idle.
  task automatic expect_frame(input string tag, input int len, input logic [7:0] w [16]);
    for (int i = 0; i < len; i++) begin
      chk_cycle($sformatf("%s.emit%0d", tag, i), 1'b1, w[i], 1'b0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
    end
    chk_cycle({tag, ".done"}, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk_cycle({tag, ".idle"}, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  // Called right after the rejected byte was taken.
  task automatic expect_reject(input string tag);
    chk_cycle({tag, ".err"}, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk_cycle({tag, ".idle"}, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  logic [7:0] w [16];
  int         base;

  initial begin
    reset    = 1'b1;
    in_data  = 8'h00;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk_cycle("reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // 1: basic three-byte frame, CHK = 11^22^44 = 77
    base = shift_cnt;
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h44); send(8'h77);
    w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h44;
    expect_frame("t1", 3, w);
    check("t1.nshift", 8'(shift_cnt - base), 8'd3);

    // 2: bad checksum (expect 30, send 31), no strobes at all
    base = shift_cnt;
    send(8'hA5); send(8'h02); send(8'h10); send(8'h20); send(8'h31);
    expect_reject("t2");
    check("t2.nshift", 8'(shift_cnt - base), 8'd0);

    // 3: LEN 0 and LEN 17 rejected right after LEN, then a good frame
    send(8'hA5); send(8'h00);
    expect_reject("t3a");
    send(8'hA5); send(8'h11);
    expect_reject("t3b");
    send(8'hA5); send(8'h01); send(8'h5A); send(8'h5A);
    w[0] = 8'h5A;
    expect_frame("t3c", 1, w);

    // 4: leading junk dropped, sync value as payload, gapped valid
    base = shift_cnt;
    send_slow(8'h00); send_slow(8'hFF); send_slow(8'hA5);
    send_slow(8'h01); send_slow(8'hA5); send_slow(8'hA5);
    w[0] = 8'hA5;
    expect_frame("t4", 1, w);
    check("t4.nshift", 8'(shift_cnt - base), 8'd1);

    // 5: full buffer, XOR of 00..0F is 00
    send(8'hA5); send(8'h10);
    for (int i = 0; i < 16; i++) begin
      send(8'(i));
      w[i] = 8'(i);
    end
    send(8'h00);
    expect_frame("t5", 16, w);

    // 6: reset after the second strobe; no done, no third strobe
    base = shift_cnt;
    send(8'hA5); send(8'h04); send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'h04);
    chk_cycle("t6.s0", 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk_cycle("t6.s1", 1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    chk_cycle("t6.rst", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk_cycle("t6.post", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t6.nshift", 8'(shift_cnt - base), 8'd2);
    send(8'hA5); send(8'h02); send(8'h3C); send(8'hC3); send(8'hFF);
    w[0] = 8'h3C; w[1] = 8'hC3;
    expect_frame("t6b", 2, w);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
